nios2_key_input_pio: RTL and testbench

//  Avalon-MM slave input PIO for the piano push-buttons/switches; the read-side counterpart of the LED output PIOs.

---
 rtl/nios2_key_input_pio.sv | 116 +++++++++++
 tb/tb_nios2_key_input_pio.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_key_input_pio.sv
// Avalon-MM input PIO: 2-FF sync + per-bit debounce, sticky edge capture, maskable level irq.
// Latency: input step -> DATA after 2+DEBOUNCE_CYCLES clocks, irq registered; zero-wait reads, never stalls the bus.
module nios2_key_input_pio #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int EDGE_TYPE       = 1,
    parameter bit STABLE_RESET    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{STABLE_RESET}};

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] stable, stable_next;
    logic [WIDTH-1:0] event_bits, qual_bits;
    logic [WIDTH-1:0] irqmask, irqmask_next;
    logic [WIDTH-1:0] edgecap, edgecap_next;
    logic [WIDTH-1:0] w1c_bits;
    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] cnt_next [WIDTH];
    logic             wr_en;

    assign wr_en = chipselect && !write_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // A bounce back to the stable value zeroes the count, so glitches shorter than the window vanish.
    always_comb begin
        stable_next = stable;
        event_bits  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_next[i] = sync2[i];
                    event_bits[i]  = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0)
            qual_bits = event_bits & stable_next;
        else if (EDGE_TYPE == 1)
            qual_bits = event_bits & ~stable_next;
        else
            qual_bits = event_bits;
    end

    // A new edge in the same cycle as its W1C keeps the flag set.
    always_comb begin
        irqmask_next = irqmask;
        w1c_bits     = '0;
        if (wr_en && address == 2'd2)
            irqmask_next = writedata[WIDTH-1:0];
        if (wr_en && address == 2'd3)
            w1c_bits = writedata[WIDTH-1:0];
        edgecap_next = (edgecap & ~w1c_bits) | qual_bits;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable  <= RST_VAL;
            irqmask <= '0;
            edgecap <= '0;
            irq     <= 1'b0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            stable  <= stable_next;
            irqmask <= irqmask_next;
            edgecap <= edgecap_next;
            irq     <= |(edgecap_next & irqmask_next);
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= cnt_next[i];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd2:    readdata[WIDTH-1:0] = irqmask;
            2'd3:    readdata[WIDTH-1:0] = edgecap;
            default: readdata = '0;
        endcase
    end

    if (WIDTH < 32) begin : g_unused_wd
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_nios2_key_input_pio.sv
// Bench for nios2_key_input_pio: falling-edge and any-edge instances share one bus, checked against a window model.
module tb_nios2_key_input_pio;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = 4'hF;
    logic [31:0] rd_fall, rd_any;
    logic        irq_fall, irq_any;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    nios2_key_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .CNT_W(2), .EDGE_TYPE(1), .STABLE_RESET(1'b1)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd_fall), .irq(irq_fall));

    nios2_key_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .CNT_W(2), .EDGE_TYPE(2), .STABLE_RESET(1'b1)) dut_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port), .readdata(rd_any), .irq(irq_any));

    // Model: a bit is accepted once the last DEB synchronised samples all disagree with it.
    logic [3:0] pipe0, pipe1, m_stable, m_mask, flip, clr;
    logic [3:0] m_edge [2];
    logic       m_irq  [2];
    logic [3:0] win [$];

    task automatic model_reset();
        pipe0 = 4'hF; pipe1 = 4'hF; win.delete();
        m_stable = 4'hF; m_mask = 4'h0;
        m_edge[0] = 4'h0; m_edge[1] = 4'h0; m_irq[0] = 1'b0; m_irq[1] = 1'b0;
    endtask

    task automatic model_step();
        bit all_diff;
        logic [3:0] ev [2];
        win.push_back(pipe1);
        if (win.size() > DEB) void'(win.pop_front());
        flip = 4'h0;
        for (int i = 0; i < 4; i++) begin
            all_diff = (win.size() == DEB);
            foreach (win[k]) if (win[k][i] == m_stable[i]) all_diff = 1'b0;
            flip[i] = all_diff;
        end
        pipe1 = pipe0;
        pipe0 = in_port;
        m_stable = m_stable ^ flip;
        ev[0] = flip & ~m_stable;
        ev[1] = flip;
        clr = 4'h0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
        if (chipselect && !write_n && address == 2'd3) clr = writedata[3:0];
        for (int j = 0; j < 2; j++) begin
            m_edge[j] = (m_edge[j] & ~clr) | ev[j];
            m_irq[j]  = |(m_edge[j] & m_mask);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    function automatic logic [31:0] exp_rd(input int j);
        case (address)
            2'd0:    return {28'd0, m_stable};
            2'd2:    return {28'd0, m_mask};
            2'd3:    return {28'd0, m_edge[j]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rd_fall", rd_fall, exp_rd(0));
        chk("model_rd_any", rd_any, exp_rd(1));
        chk("model_irq_fall", {31'd0, irq_fall}, {31'd0, m_irq[0]});
        chk("model_irq_any", {31'd0, irq_any}, {31'd0, m_irq[1]});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            chipselect = 1'b0; write_n = 1'b1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic peek(input string name, input logic [1:0] a, input logic [31:0] ef, input logic [31:0] ea);
        @(negedge clk); #1;
        address = a;
        @(negedge clk);
        chk({name, "_fall"}, rd_fall, ef);
        chk({name, "_any"}, rd_any, ea);
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk); #1;
        in_port = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset asserted between clock edges; outputs must clear without a clock.
        #3 reset = 1'b1;
        #1 chk("rst_data", rd_fall, 32'hF);
        address = 2'd2; #1 chk("rst_mask", rd_fall, 32'h0);
        address = 2'd3; #1 chk("rst_edge", rd_any, 32'h0);
        chk("rst_irq", {31'd0, irq_fall}, 32'd0);
        @(negedge clk); #1 reset = 1'b0;
        idle(3);

        // Clean press of bit0: DATA changes exactly 6 clocks later.
        @(negedge clk); #1;
        address = 2'd0; in_port = 4'hE;
        repeat (5) @(negedge clk);
        chk("press_data_before", rd_fall, 32'hF);
        @(negedge clk);
        chk("press_data_at6", rd_fall, 32'hE);
        peek("press_edge", 2'd3, 32'h1, 32'h1);
        chk("press_irq", {31'd0, irq_fall}, 32'd0);

        // Three-clock glitch on bit1 is rejected.
        press(4'hC); idle(2); press(4'hE);
        idle(10);
        peek("glitch_data", 2'd0, 32'hE, 32'hE);
        peek("glitch_edge", 2'd3, 32'h1, 32'h1);

        wr(2'd3, 32'hF);
        peek("clear_all", 2'd3, 32'h0, 32'h0);

        // Release: rising edge ignored by the falling-edge instance only.
        press(4'hF); idle(9);
        peek("release_data", 2'd0, 32'hF, 32'hF);
        peek("release_edge", 2'd3, 32'h0, 32'h1);

        wr(2'd3, 32'h1);
        wr(2'd2, 32'h1);
        peek("mask", 2'd2, 32'h1, 32'h1);

        // IRQ path with mask bit0 set.
        @(negedge clk); #1;
        address = 2'd3; in_port = 4'hE;
        repeat (5) @(negedge clk);
        chk("irq_before", {31'd0, irq_fall}, 32'd0);
        @(negedge clk);
        chk("irq_edge", rd_fall, 32'h1);
        chk("irq_set_fall", {31'd0, irq_fall}, 32'd1);
        chk("irq_set_any", {31'd0, irq_any}, 32'd1);
        wr(2'd3, 32'h1);
        chk("irq_w1c_edge", rd_fall, 32'h0);
        chk("irq_w1c_irq", {31'd0, irq_fall}, 32'd0);

        // W1C of bit2 lands on the same edge as the bit2 event: set wins.
        @(negedge clk); #1;
        in_port = 4'hA;
        repeat (5) @(negedge clk);
        #1 address = 2'd3; writedata = 32'h4; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk); #1 chipselect = 1'b0; write_n = 1'b1;
        chk("collide_fall", rd_fall, 32'h4);
        chk("collide_any", rd_any, 32'h4);
        chk("collide_irq", {31'd0, irq_fall}, 32'd0);

        // Writes to DATA and the reserved word change nothing.
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        peek("ro_data", 2'd0, 32'hA, 32'hA);
        peek("ro_rsvd", 2'd1, 32'h0, 32'h0);
        peek("ro_mask", 2'd2, 32'h1, 32'h1);
        peek("ro_edge", 2'd3, 32'h4, 32'h4);

        // Reset in the middle of a bit3 debounce.
        press(4'h2); idle(3);
        @(posedge clk); #3 reset = 1'b1;
        #1 address = 2'd0;
        #1 chk("mid_rst_data", rd_fall, 32'hF);
        address = 2'd2; #1 chk("mid_rst_mask", rd_any, 32'h0);
        address = 2'd3; #1 chk("mid_rst_edge", rd_fall, 32'h0);
        chk("mid_rst_irq", {31'd0, irq_any}, 32'd0);
        @(negedge clk); #1 reset = 1'b0; in_port = 4'hF;
        idle(10);
        peek("post_rst_data", 2'd0, 32'hF, 32'hF);
        peek("post_rst_edge", 2'd3, 32'h0, 32'h0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
